// File: rtl/comp2_pkg.sv
// Shared types and constants for the bit-serial two's-complement decoder.
// Optional build macro used by the decoder: COMP2_MINNEG_SAT_EN.
package comp2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int C2_WIDTH = 5;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/comp2_bit_cell.sv
// One-bit serial negation cell: copy bits up to the first 1, invert after it when negative.
module comp2_bit_cell (
  input  logic b,
  input  logic sgn,
  input  logic seen_in,
  output logic out,
  output logic seen_out
);

  assign out      = (sgn & seen_in) ? ~b : b;
  assign seen_out = seen_in | b;

endmodule

// File: rtl/comp2_serial_decoder.sv
// Bit-serial two's-complement to sign-magnitude decoder, LSB first, WIDTH+1 cycles per word.
// COMP2_MINNEG_SAT_EN: saturate the magnitude of the most negative input to 2^(WIDTH-1)-1.
module comp2_serial_decoder
  import comp2_pkg::*;
#(
  parameter int WIDTH = C2_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             sign,
  output logic [WIDTH-1:0] mag,
  output logic             min_neg
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MIN_PAT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SAT_PAT = {1'b0, {(WIDTH-1){1'b1}}};

  state_t           state, state_next;
  logic [WIDTH-1:0] sr;
  logic             sgn;
  logic [CW-1:0]    cnt;
  logic             seen_one;
  // Only the upper WIDTH-1 result bits need storing; the last bit joins on the final edge.
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             cell_out;
  logic             cell_seen;
  logic             accept;
  logic             last;
  logic             busy_next;
  logic             done_next;
  logic [WIDTH-1:0] mag_next;

  comp2_bit_cell u_cell (
    .b       (sr[0]),
    .sgn     (sgn),
    .seen_in (seen_one),
    .out     (cell_out),
    .seen_out(cell_seen)
  );

  assign acc_next = {cell_out, acc};
  assign last     = (state == ST_SHIFT) && (cnt == CW'(WIDTH - 1));
  assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));

`ifdef COMP2_MINNEG_SAT_EN
  assign mag_next = (sgn && (acc_next == MIN_PAT)) ? SAT_PAT : acc_next;
`else
  assign mag_next = acc_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SHIFT;
          busy_next  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (last) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
        end else begin
          busy_next  = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_next = ST_SHIFT;
          busy_next  = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      sgn      <= 1'b0;
      cnt      <= '0;
      seen_one <= 1'b0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sign     <= 1'b0;
      mag      <= '0;
      min_neg  <= 1'b0;
    end else begin
      busy <= busy_next;
      done <= done_next;
      if (accept) begin
        sr       <= din;
        sgn      <= din[WIDTH-1];
        cnt      <= '0;
        seen_one <= 1'b0;
        acc      <= '0;
      end else if (state == ST_SHIFT) begin
        sr       <= sr >> 1;
        cnt      <= cnt + 1'b1;
        seen_one <= cell_seen;
        acc      <= acc_next[WIDTH-1:1];
        if (last) begin
          mag     <= mag_next;
          sign    <= sgn;
          min_neg <= sgn && (acc_next == MIN_PAT);
        end
      end
    end
  end

endmodule

// File: tb/tb_comp2_serial_decoder.sv
// Self-checking bench: directed cases plus random start/din traffic against an arithmetic model.
module tb_comp2_serial_decoder;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] din = '0;
  logic         busy, done, sign, min_neg;
  logic [W-1:0] mag;

  int checks = 0;
  int errors = 0;

  comp2_serial_decoder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din),
    .busy(busy), .done(done), .sign(sign), .mag(mag), .min_neg(min_neg)
  );

  always #5 clk = ~clk;

  // Expected magnitude from plain arithmetic: |value| as a WIDTH-bit pattern.
  function automatic logic [W-1:0] exp_mag(input logic [W-1:0] d);
    int unsigned v;
    v = d;
    if (d[W-1]) v = (1 << W) - v;
`ifdef COMP2_MINNEG_SAT_EN
    if (v == (1 << (W-1))) v = (1 << (W-1)) - 1;
`endif
    return v[W-1:0];
  endfunction

  function automatic logic exp_min(input logic [W-1:0] d);
    return d == W'(1 << (W-1));
  endfunction

  // Model: a conversion occupies W busy cycles, then one done cycle.
  int           m_left = 0;
  logic         m_done = 0, m_sign = 0, m_min = 0;
  logic [W-1:0] m_mag = '0, m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_done = 0; m_sign = 0; m_min = 0; m_mag = '0; m_pend = '0;
    end else begin
      int old_left;
      old_left = m_left;
      m_done = (old_left == 1);
      if (old_left > 0) m_left = old_left - 1;
      if (m_done) begin
        m_sign = m_pend[W-1];
        m_mag  = exp_mag(m_pend);
        m_min  = exp_min(m_pend);
      end
      if (start && old_left == 0) begin
        m_left = W;
        m_pend = din;
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({busy, done, sign, mag, min_neg} !== {(m_left > 0), m_done, m_sign, m_mag, m_min}) begin
      errors++;
      $display("FAIL model t=%0t got busy=%b done=%b sign=%b mag=%b min=%b want busy=%b done=%b sign=%b mag=%b min=%b",
               $time, busy, done, sign, mag, min_neg, (m_left > 0), m_done, m_sign, m_mag, m_min);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Wait after the accept edge for done; returns the number of edges it took.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin n = i; break; end
    end
    if (n == 0) check("done_timeout", 0, 1);
  endtask

  task automatic convert(input logic [W-1:0] d, input logic s, input logic [W-1:0] m,
                         input logic mn, input string name);
    int n;
    @(negedge clk); start = 1'b1; din = d;
    @(posedge clk); #1; start = 1'b0; din = $urandom;
    check({name, "_busy"}, busy, 1);
    wait_done(n);
    check({name, "_latency"}, n, W);
    check({name, "_sign"}, sign, s);
    check({name, "_mag"}, mag, m);
    check({name, "_minneg"}, min_neg, mn);
  endtask

  initial begin
    int n;
    int dones;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {busy, done, sign, mag, min_neg}, 0);
    @(negedge clk); rst_n = 1'b1;

    check("model_m5", exp_mag(5'b11011), 5'b00101);
    check("model_min", exp_min(5'b10000), 1);

    convert(5'b00101, 0, 5'b00101, 0, "pos5");
    convert(5'b11011, 1, 5'b00101, 0, "neg5");
    convert(5'b11111, 1, 5'b00001, 0, "neg1");
`ifdef COMP2_MINNEG_SAT_EN
    convert(5'b10000, 1, 5'b01111, 1, "minneg");
`else
    convert(5'b10000, 1, 5'b10000, 1, "minneg");
`endif
    convert(5'b01111, 0, 5'b01111, 0, "maxpos");

    // start during SHIFT is ignored
    @(negedge clk); start = 1'b1; din = 5'b11011;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1; din = 5'b00011;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) break;
    end
    check("ignore_done", done, 1);
    check("ignore_mag", mag, 5'b00101);
    dones = 0;
    for (int i = 0; i < 2*W; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("ignore_no_extra", dones, 0);

    // back-to-back: start asserted in the DONE cycle
    @(negedge clk); start = 1'b1; din = 5'b11011;
    @(posedge clk); #1; start = 1'b0;
    wait_done(n);
    start = 1'b1; din = 5'b11110;
    @(posedge clk); #1; start = 1'b0;
    check("b2b_busy", busy, 1);
    wait_done(n);
    check("b2b_latency", n, W);
    check("b2b_mag", mag, 5'b00010);
    check("b2b_sign", sign, 1);

    // asynchronous reset in the 3rd SHIFT cycle
    @(negedge clk); start = 1'b1; din = 5'b11011;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check("async_reset", {busy, done, sign, mag, min_neg}, 0);
    dones = 0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("reset_no_done", dones, 0);
    @(negedge clk); rst_n = 1'b1;
    convert(5'b00000, 0, 5'b00000, 0, "zero");

    // random traffic, checked every cycle by the model comparison
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      din = $urandom;
    end
    @(negedge clk); start = 1'b0;
    repeat (W + 3) @(posedge clk);
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
